// File: rtl/rle_pkg.sv
// Shared definitions for the RLE encoder/decoder pair: FSM states, default widths, pair layout.
package rle_pkg;
  localparam int RLE_DATA_W  = 8;
  localparam int RLE_CNT_W   = 8;
  localparam int RLE_MAX_RUN = 255;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    FLUSH = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } rle_state_t;

  typedef struct packed {
    logic [RLE_DATA_W-1:0] data;
    logic [RLE_CNT_W-1:0]  count;
  } rle_pair_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    if (value == 32'hFFFF_FFFF) begin
      return value;
    end else begin
      return value + 32'd1;
    end
  endfunction
endpackage

// File: rtl/rle_encoder_if.sv
// Pixel-in / pair-out handshake bundle of the RLE encoder; master drives pixels, slave is the encoder.
interface rle_encoder_if
  import rle_pkg::*;
#(
  parameter int DATA_W = RLE_DATA_W,
  parameter int CNT_W  = RLE_CNT_W
);
  logic [DATA_W-1:0] pixel_in;
  logic              valid_in;
  logic              last_in;
  logic              ready_in;
  logic [DATA_W-1:0] data_out;
  logic [CNT_W-1:0]  count_out;
  logic              valid_out;
  logic              ready_out;

  modport master (
    output pixel_in, valid_in, last_in, ready_out,
    input  ready_in, data_out, count_out, valid_out
  );

  modport slave (
    input  pixel_in, valid_in, last_in, ready_out,
    output ready_in, data_out, count_out, valid_out
  );
endinterface

// File: rtl/rle_out_reg.sv
// Single-entry valid/ready holding register for one (pixel, count) pair.
module rle_out_reg
  import rle_pkg::*;
#(
  parameter type PAIR_T = rle_pair_t
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  PAIR_T load_pair,
  input  logic  ready_out,
  output logic  valid_out,
  output PAIR_T pair_out,
  output logic  free
);
  logic  valid_r;
  PAIR_T pair_r;

  // Load wins over drain; a taken pair drops valid but keeps its last value on the bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_r <= 1'b0;
      pair_r  <= '0;
    end else if (load) begin
      valid_r <= 1'b1;
      pair_r  <= load_pair;
    end else if (valid_r && ready_out) begin
      valid_r <= 1'b0;
    end
  end

  assign valid_out = valid_r;
  assign pair_out  = pair_r;
  assign free      = !valid_r || ready_out;
endmodule

// File: rtl/rle_encoder.sv
// Streaming run-length encoder: pixels in, (pixel, run count) pairs out, framed by start/last_in/done.
// Optional build macro RLE_ENCODER_STATS_EN adds pix_cnt/pair_cnt frame statistics outputs.
module rle_encoder
  import rle_pkg::*;
#(
  parameter int DATA_W  = RLE_DATA_W,
  parameter int CNT_W   = RLE_CNT_W,
  parameter int MAX_RUN = RLE_MAX_RUN
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  rle_encoder_if.slave  bus,
  output logic          done
`ifdef RLE_ENCODER_STATS_EN
  ,
  output logic [31:0]   pix_cnt,
  output logic [31:0]   pair_cnt
`endif
);
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CNT_W-1:0]  count;
  } pair_t;

  rle_state_t        state_r, state_next_s;
  logic [DATA_W-1:0] cur_pix_r;
  logic [CNT_W-1:0]  cur_cnt_r;
  logic              done_r;

  logic  ready_in_s, accept_s, take_s;
  logic  run_open_s, run_match_s;
  logic  load_s, run_clear_s, run_new_s, run_inc_s;
  pair_t load_pair_s, out_pair_s;
  logic  out_valid_s, out_free_s;

  assign ready_in_s  = (state_r == RUN) && out_free_s;
  assign accept_s    = bus.valid_in && ready_in_s;
  assign take_s      = out_valid_s && bus.ready_out;
  assign run_open_s  = (cur_cnt_r != '0);
  assign run_match_s = (bus.pixel_in == cur_pix_r) && (cur_cnt_r < CNT_W'(MAX_RUN));

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    if (start) state_next_s = RUN;
               else       state_next_s = IDLE;
      RUN:     if (accept_s && bus.last_in) state_next_s = FLUSH;
               else                         state_next_s = RUN;
      FLUSH:   if (out_free_s) state_next_s = DRAIN;
               else            state_next_s = FLUSH;
      DRAIN:   if (take_s) state_next_s = DONE;
               else        state_next_s = DRAIN;
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Run control and pair loading; a closing pixel emits the old run and reopens with itself.
  always_comb begin
    load_s      = 1'b0;
    run_clear_s = 1'b0;
    run_new_s   = 1'b0;
    run_inc_s   = 1'b0;
    load_pair_s = '{data: cur_pix_r, count: cur_cnt_r};
    case (state_r)
      IDLE: run_clear_s = 1'b1;
      RUN: begin
        if (accept_s) begin
          if (run_open_s && run_match_s) begin
            run_inc_s = 1'b1;
          end else begin
            run_new_s = 1'b1;
            load_s    = run_open_s;
          end
        end else begin
          run_inc_s = 1'b0;
        end
      end
      FLUSH: begin
        if (out_free_s) begin
          load_s      = 1'b1;
          run_clear_s = 1'b1;
        end else begin
          load_s = 1'b0;
        end
      end
      default: run_clear_s = 1'b0;
    endcase
  end

  // Open-run registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_pix_r <= '0;
      cur_cnt_r <= '0;
    end else if (run_clear_s) begin
      cur_cnt_r <= '0;
    end else if (run_new_s) begin
      cur_pix_r <= bus.pixel_in;
      cur_cnt_r <= CNT_W'(1);
    end else if (run_inc_s) begin
      cur_cnt_r <= cur_cnt_r + CNT_W'(1);
    end
  end

  // done is high exactly while the FSM sits in DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_r <= 1'b0;
    end else begin
      done_r <= (state_next_s == DONE);
    end
  end

  rle_out_reg #(.PAIR_T(pair_t)) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (load_s),
    .load_pair (load_pair_s),
    .ready_out (bus.ready_out),
    .valid_out (out_valid_s),
    .pair_out  (out_pair_s),
    .free      (out_free_s)
  );

  assign bus.ready_in  = ready_in_s;
  assign bus.valid_out = out_valid_s;
  assign bus.data_out  = out_pair_s.data;
  assign bus.count_out = out_pair_s.count;
  assign done          = done_r;

`ifdef RLE_ENCODER_STATS_EN
  logic [31:0] pix_cnt_r, pair_cnt_r;

  // Per-frame counters, cleared when a frame is armed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_cnt_r  <= 32'd0;
      pair_cnt_r <= 32'd0;
    end else if ((state_r == IDLE) && start) begin
      pix_cnt_r  <= 32'd0;
      pair_cnt_r <= 32'd0;
    end else begin
      if (accept_s) pix_cnt_r  <= sat_inc32(pix_cnt_r);
      if (take_s)   pair_cnt_r <= sat_inc32(pair_cnt_r);
    end
  end

  assign pix_cnt  = pix_cnt_r;
  assign pair_cnt = pair_cnt_r;
`endif
endmodule

// File: tb/tb_rle_encoder.sv
// Randomized self-checking bench for rle_encoder against a run-splitting reference model.
module tb_rle_encoder;
  import rle_pkg::*;

  localparam int MAX_RUN = 255;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic done;
`ifdef RLE_ENCODER_STATS_EN
  logic [31:0] pix_cnt, pair_cnt;
`endif

  rle_encoder_if #(.DATA_W(8), .CNT_W(8)) bus ();

  rle_encoder #(.DATA_W(8), .CNT_W(8), .MAX_RUN(MAX_RUN)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bus   (bus),
    .done  (done)
`ifdef RLE_ENCODER_STATS_EN
    ,
    .pix_cnt  (pix_cnt),
    .pair_cnt (pair_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned data;
    int unsigned count;
  } exp_pair_t;

  exp_pair_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int rdy_mode = 0;
  int done_seen = 0;
  int exp_pix = 0;
  int exp_pairs = 0;
  bit tail = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: group into maximal runs, then split each into full MAX_RUN pairs plus remainder.
  function automatic void model(input logic [7:0] px[$]);
    int i, j, len;
    i = 0;
    while (i < px.size()) begin
      j = i;
      while (j < px.size() && px[j] == px[i]) j++;
      len = j - i;
      for (int k = 0; k < len / MAX_RUN; k++) exp_q.push_back('{int'(px[i]), MAX_RUN});
      if (len % MAX_RUN != 0) exp_q.push_back('{int'(px[i]), len % MAX_RUN});
      i = j;
    end
  endfunction

  initial begin
    bus.ready_out = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.ready_out = 1'b1;
        1:       bus.ready_out = ~bus.ready_out;
        default: bus.ready_out = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  logic       prev_valid = 1'b0, prev_ready = 1'b0, prev_take = 1'b0, prev_done = 1'b0;
  logic [7:0] prev_data = 8'd0, prev_count = 8'd0;
  exp_pair_t  mon_e;

  always @(negedge clk) begin
    if (rst) begin
      if (bus.valid_out && bus.ready_out) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_pair", {bus.data_out, bus.count_out}, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check_val("pair_data", bus.data_out, mon_e.data);
          check_val("pair_count", bus.count_out, mon_e.count);
        end
        check_val("count_range", (bus.count_out != 8'd0) && (bus.count_out <= 8'(MAX_RUN)), 1);
      end
      if (prev_valid && !prev_ready) begin
        check_val("stall_valid", bus.valid_out, 1);
        check_val("stall_hold", {bus.data_out, bus.count_out}, {prev_data, prev_count});
      end
      if (bus.valid_out && !bus.ready_out) check_val("stall_ready_in", bus.ready_in, 0);
      if (tail) check_val("tail_ready_in", bus.ready_in, 0);
      if (done) begin
        check_val("done_after_take", prev_take, 1);
        check_val("done_drained", exp_q.size(), 0);
        check_val("done_pulse", prev_done, 0);
`ifdef RLE_ENCODER_STATS_EN
        check_val("stats_pix", pix_cnt, exp_pix);
        check_val("stats_pair", pair_cnt, exp_pairs);
`endif
        done_seen++;
        tail = 1'b0;
      end
      prev_valid = bus.valid_out;
      prev_ready = bus.ready_out;
      prev_take  = bus.valid_out && bus.ready_out;
      prev_done  = done;
      prev_data  = bus.data_out;
      prev_count = bus.count_out;
    end else begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
      prev_take  = 1'b0;
      prev_done  = 1'b0;
    end
  end

  task automatic pulse_start();
    @(posedge clk);
    #1;
    bus.valid_in = 1'b1;
    bus.pixel_in = 8'hEE;
    bus.last_in  = 1'b1;
    @(negedge clk);
    check_val("idle_ready_in", bus.ready_in, 0);
    @(posedge clk);
    #1;
    start = 1'b1;
    bus.valid_in = 1'b0;
    bus.last_in  = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
`ifdef RLE_ENCODER_STATS_EN
    check_val("stats_clear_pix", pix_cnt, 0);
    check_val("stats_clear_pair", pair_cnt, 0);
`endif
  endtask

  // Presents px[i] and returns on the negedge before the edge that accepts it; 0 on timeout.
  task automatic offer_pixel(input logic [7:0] pix, input bit last, input int gap_pct, output bit ok);
    int budget;
    @(posedge clk);
    #1;
    if ($urandom_range(0, 99) < gap_pct) begin
      bus.valid_in = 1'b0;
      @(posedge clk);
      #1;
    end
    bus.pixel_in = pix;
    bus.valid_in = 1'b1;
    bus.last_in  = last;
    budget = 0;
    @(negedge clk);
    while (!bus.ready_in && budget < 1000) begin
      @(negedge clk);
      budget++;
    end
    ok = (budget < 1000);
    if (!ok) check_val("accept_timeout", 0, 1);
  endtask

  task automatic run_frame(input logic [7:0] px[$], input int gap_pct);
    bit ok;
    int budget;
    exp_q.delete();
    model(px);
    exp_pix   = px.size();
    exp_pairs = exp_q.size();
    done_seen = 0;
    pulse_start();
    ok = 1'b1;
    for (int i = 0; i < px.size() && ok; i++) offer_pixel(px[i], i == px.size() - 1, gap_pct, ok);
    @(posedge clk);
    #1;
    tail = 1'b1;
    bus.pixel_in = 8'($urandom_range(0, 255));
    bus.valid_in = 1'b1;
    bus.last_in  = 1'($urandom_range(0, 1));
    budget = 0;
    while (done_seen == 0 && budget < 3000) begin
      @(posedge clk);
      budget++;
    end
    check_val("frame_done", done_seen, 1);
    tail = 1'b0;
    #1;
    bus.valid_in = 1'b0;
    bus.last_in  = 1'b0;
  endtask

  logic [7:0] frame[$];
  bit         ok_r;

  initial begin
    bus.pixel_in = 8'd0;
    bus.valid_in = 1'b0;
    bus.last_in  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_ready_in", bus.ready_in, 0);
    check_val("rst_valid_out", bus.valid_out, 0);
    check_val("rst_done", done, 0);
    check_val("rst_data_out", bus.data_out, 0);
    check_val("rst_count_out", bus.count_out, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    frame = '{8'h01, 8'h01, 8'h02, 8'h02, 8'h02, 8'h03, 8'h04, 8'h04};
    run_frame(frame, 0);

    frame.delete();
    for (int i = 0; i < 300; i++) frame.push_back(8'hAA);
    run_frame(frame, 0);

    frame = '{8'h5C};
    run_frame(frame, 0);

    rdy_mode = 1;
    frame = '{8'h01, 8'h01, 8'h02, 8'h02, 8'h02, 8'h03, 8'h04, 8'h04};
    run_frame(frame, 0);
    rdy_mode = 0;

    // Mid-frame reset: three identical pixels leave only an open run, nothing emitted.
    exp_q.delete();
    done_seen = 0;
    pulse_start();
    for (int i = 0; i < 3; i++) offer_pixel(8'h07, 1'b0, 0, ok_r);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.valid_in = 1'b0;
    @(negedge clk);
    check_val("mid_rst_ready_in", bus.ready_in, 0);
    check_val("mid_rst_valid_out", bus.valid_out, 0);
    check_val("mid_rst_done", done, 0);
    check_val("mid_rst_data_out", bus.data_out, 0);
    check_val("mid_rst_count_out", bus.count_out, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    check_val("mid_rst_no_done", done_seen, 0);
    frame = '{8'h01, 8'h01};
    run_frame(frame, 0);

    rdy_mode = 2;
    for (int f = 0; f < 12; f++) begin
      frame.delete();
      for (int s = 0; s < int'($urandom_range(1, 12)); s++) begin
        if ($urandom_range(0, 7) == 0) begin
          for (int r = 0; r < int'($urandom_range(200, 560)); r++) frame.push_back(8'h3C);
        end else begin
          for (int r = 0; r < int'($urandom_range(1, 4)); r++) frame.push_back(8'($urandom_range(0, 2)));
        end
      end
      run_frame(frame, 30);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
